// File: rtl/branch_resolution_queue.sv
// ---------------------------------------------------------------------------
// branch_resolution_queue
//
// In-order branch/JALR resolution queue feeding predictor updates back to
// fetch. Entries are allocated at dispatch, up to 3 per cycle, on packed lanes.
// Execute resolves them out of order, up to 3 per cycle, by tag. The queue
// retires from the head in program order, up to 3 per cycle.
//
// A mispredicted retirement suppresses the younger lanes and restores the RAS.
// It then flushes the whole queue at the clock edge.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   alloc_*_i_k, alloc_valid_i allocation lanes (packed 000/001/011/111)
//   alloc_ready_o, alloc_tag_o_k  >=3 free and no flush; tag of lane k
//   resolve_*_i_k              resolution lanes, any valid pattern
//   misprediction_o_k, update_valid_o_k, is_jalr_o_k, pc_at_prediction_o_k,
//   correct_pc_o_k, update_global_history_o_k   retire lane k
//   ras_restore_en_o, ras_restore_tos_o         RAS checkpoint restore
//   occupancy_o, empty_o, full_o                queue status
//
// Build option: define BRQ_CORRECT_UPDATE_EN to train the predictor on
// correctly predicted retirements too. When it is undefined, only
// mispredicted lanes drive outputs.
// ---------------------------------------------------------------------------
module branch_resolution_queue #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int ENTRIES     = 32,
   parameter int INDEX_WIDTH = $clog2(ENTRIES),
   parameter int GHW         = INDEX_WIDTH + 3,
   parameter int TW          = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            alloc_valid_i,
   input  logic                  alloc_is_jalr_i_0,
   input  logic                  alloc_is_jalr_i_1,
   input  logic                  alloc_is_jalr_i_2,
   input  logic [DATA_WIDTH-1:0] alloc_pc_at_prediction_i_0,
   input  logic [DATA_WIDTH-1:0] alloc_pc_at_prediction_i_1,
   input  logic [DATA_WIDTH-1:0] alloc_pc_at_prediction_i_2,
   input  logic [GHW-1:0]        alloc_global_history_i_0,
   input  logic [GHW-1:0]        alloc_global_history_i_1,
   input  logic [GHW-1:0]        alloc_global_history_i_2,
   input  logic [2:0]            alloc_ras_tos_i_0,
   input  logic [2:0]            alloc_ras_tos_i_1,
   input  logic [2:0]            alloc_ras_tos_i_2,
   output logic                  alloc_ready_o,
   output logic [TW-1:0]         alloc_tag_o_0,
   output logic [TW-1:0]         alloc_tag_o_1,
   output logic [TW-1:0]         alloc_tag_o_2,
   input  logic [2:0]            resolve_valid_i,
   input  logic [TW-1:0]         resolve_tag_i_0,
   input  logic [TW-1:0]         resolve_tag_i_1,
   input  logic [TW-1:0]         resolve_tag_i_2,
   input  logic                  resolve_mispredict_i_0,
   input  logic                  resolve_mispredict_i_1,
   input  logic                  resolve_mispredict_i_2,
   input  logic [DATA_WIDTH-1:0] resolve_correct_pc_i_0,
   input  logic [DATA_WIDTH-1:0] resolve_correct_pc_i_1,
   input  logic [DATA_WIDTH-1:0] resolve_correct_pc_i_2,
   output logic                  misprediction_o_0,
   output logic                  misprediction_o_1,
   output logic                  misprediction_o_2,
   output logic                  update_valid_o_0,
   output logic                  update_valid_o_1,
   output logic                  update_valid_o_2,
   output logic                  is_jalr_o_0,
   output logic                  is_jalr_o_1,
   output logic                  is_jalr_o_2,
   output logic [DATA_WIDTH-1:0] pc_at_prediction_o_0,
   output logic [DATA_WIDTH-1:0] pc_at_prediction_o_1,
   output logic [DATA_WIDTH-1:0] pc_at_prediction_o_2,
   output logic [DATA_WIDTH-1:0] correct_pc_o_0,
   output logic [DATA_WIDTH-1:0] correct_pc_o_1,
   output logic [DATA_WIDTH-1:0] correct_pc_o_2,
   output logic [GHW-1:0]        update_global_history_o_0,
   output logic [GHW-1:0]        update_global_history_o_1,
   output logic [GHW-1:0]        update_global_history_o_2,
   output logic                  ras_restore_en_o,
   output logic [2:0]            ras_restore_tos_o,
   output logic [TW:0]           occupancy_o,
   output logic                  empty_o,
   output logic                  full_o
);

   localparam int PW = TW + 1;

`ifdef BRQ_CORRECT_UPDATE_EN
   localparam bit CORRECT_UPDATE = 1'b1;
`else
   localparam bit CORRECT_UPDATE = 1'b0;
`endif

   // Pointers carry a wrap bit so full and empty are distinguishable.
   logic [PW-1:0]         head_q, tail_q;
   logic [DEPTH-1:0]      vld_q, res_q, mp_q, jalr_q;
   logic [DATA_WIDTH-1:0] pc_q  [DEPTH];
   logic [DATA_WIDTH-1:0] cpc_q [DEPTH];
   logic [GHW-1:0]        gh_q  [DEPTH];
   logic [2:0]            ras_q [DEPTH];

   // Gather the per-lane ports into arrays.
   logic [2:0]            al_jalr;
   logic [DATA_WIDTH-1:0] al_pc  [3];
   logic [GHW-1:0]        al_gh  [3];
   logic [2:0]            al_ras [3];
   logic [TW-1:0]         rtag   [3];
   logic [2:0]            rmp;
   logic [DATA_WIDTH-1:0] rcpc   [3];

   assign al_jalr = {alloc_is_jalr_i_2, alloc_is_jalr_i_1, alloc_is_jalr_i_0};
   assign al_pc[0] = alloc_pc_at_prediction_i_0;
   assign al_pc[1] = alloc_pc_at_prediction_i_1;
   assign al_pc[2] = alloc_pc_at_prediction_i_2;
   assign al_gh[0] = alloc_global_history_i_0;
   assign al_gh[1] = alloc_global_history_i_1;
   assign al_gh[2] = alloc_global_history_i_2;
   assign al_ras[0] = alloc_ras_tos_i_0;
   assign al_ras[1] = alloc_ras_tos_i_1;
   assign al_ras[2] = alloc_ras_tos_i_2;
   assign rtag[0] = resolve_tag_i_0;
   assign rtag[1] = resolve_tag_i_1;
   assign rtag[2] = resolve_tag_i_2;
   assign rmp = {resolve_mispredict_i_2, resolve_mispredict_i_1, resolve_mispredict_i_0};
   assign rcpc[0] = resolve_correct_pc_i_0;
   assign rcpc[1] = resolve_correct_pc_i_1;
   assign rcpc[2] = resolve_correct_pc_i_2;

   // Slot indices for retire lanes (from head) and alloc lanes (from tail).
   logic [TW-1:0] ridx [3];
   logic [TW-1:0] atag [3];

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         ridx[k] = head_q[TW-1:0] + TW'(k);
         atag[k] = tail_q[TW-1:0] + TW'(k);
      end
   end

   // Retire selection: a contiguous resolved run from head, cut after the
   // first mispredicted entry.
   logic [2:0]    elig, ret_mp;
   logic          flush, chain;
   logic [PW-1:0] n_ret;
   logic [2:0]    flush_tos;

   always_comb begin
      elig      = '0;
      ret_mp    = '0;
      flush     = 1'b0;
      chain     = 1'b1;
      n_ret     = '0;
      flush_tos = '0;
      for (int k = 0; k < 3; k++) begin
         if (chain && vld_q[ridx[k]] && res_q[ridx[k]]) begin
            elig[k] = 1'b1;
            n_ret   = n_ret + PW'(1);
            if (mp_q[ridx[k]]) begin
               ret_mp[k] = 1'b1;
               flush     = 1'b1;
               flush_tos = ras_q[ridx[k]];
               chain     = 1'b0;
            end
         end else begin
            chain = 1'b0;
         end
      end
   end

   // A retired lane is visible only when it trains the predictor.
   logic [2:0]            show;
   logic [2:0]            o_jalr;
   logic [DATA_WIDTH-1:0] o_pc  [3];
   logic [DATA_WIDTH-1:0] o_cpc [3];
   logic [GHW-1:0]        o_gh  [3];

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         show[k]   = elig[k] & (CORRECT_UPDATE | ret_mp[k]);
         o_jalr[k] = show[k] & jalr_q[ridx[k]];
         o_pc[k]   = show[k] ? pc_q[ridx[k]]  : '0;
         o_cpc[k]  = show[k] ? cpc_q[ridx[k]] : '0;
         o_gh[k]   = show[k] ? gh_q[ridx[k]]  : '0;
      end
   end

   logic [PW-1:0] occ, free_cnt, alloc_cnt;
   logic          alloc_fire;

   assign occ        = tail_q - head_q;
   assign free_cnt   = PW'(DEPTH) - occ;
   assign alloc_cnt  = PW'(alloc_valid_i[0]) + PW'(alloc_valid_i[1]) + PW'(alloc_valid_i[2]);
   assign alloc_fire = alloc_ready_o & (|alloc_valid_i);

   assign alloc_ready_o = (free_cnt >= PW'(3)) & ~flush;
   assign occupancy_o   = occ;
   assign empty_o       = (occ == '0);
   assign full_o        = (occ == PW'(DEPTH));
   assign alloc_tag_o_0 = atag[0];
   assign alloc_tag_o_1 = atag[1];
   assign alloc_tag_o_2 = atag[2];

   assign misprediction_o_0 = ret_mp[0];
   assign misprediction_o_1 = ret_mp[1];
   assign misprediction_o_2 = ret_mp[2];
   assign update_valid_o_0  = show[0];
   assign update_valid_o_1  = show[1];
   assign update_valid_o_2  = show[2];
   assign is_jalr_o_0 = o_jalr[0];
   assign is_jalr_o_1 = o_jalr[1];
   assign is_jalr_o_2 = o_jalr[2];
   assign pc_at_prediction_o_0 = o_pc[0];
   assign pc_at_prediction_o_1 = o_pc[1];
   assign pc_at_prediction_o_2 = o_pc[2];
   assign correct_pc_o_0 = o_cpc[0];
   assign correct_pc_o_1 = o_cpc[1];
   assign correct_pc_o_2 = o_cpc[2];
   assign update_global_history_o_0 = o_gh[0];
   assign update_global_history_o_1 = o_gh[1];
   assign update_global_history_o_2 = o_gh[2];
   assign ras_restore_en_o  = flush;
   assign ras_restore_tos_o = flush_tos;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         vld_q  <= '0;
         res_q  <= '0;
         mp_q   <= '0;
         jalr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]  <= '0;
            cpc_q[i] <= '0;
            gh_q[i]  <= '0;
            ras_q[i] <= '0;
         end
      end else begin
         // Walk the lanes from high to low so lane 0 has the final write on a duplicate tag.
         // Entries that are retiring are already resolved, so a resolve to them is ignored.
         for (int k = 2; k >= 0; k--) begin
            if (resolve_valid_i[k] && vld_q[rtag[k]] && !res_q[rtag[k]]) begin
               res_q[rtag[k]] <= 1'b1;
               mp_q[rtag[k]]  <= rmp[k];
               cpc_q[rtag[k]] <= rcpc[k];
            end
         end
         head_q <= head_q + n_ret;
         if (flush) begin
            // Everything younger than the mispredict is wrong-path: drop it all.
            tail_q <= head_q + n_ret;
            vld_q  <= '0;
            res_q  <= '0;
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (elig[k]) begin
                  vld_q[ridx[k]] <= 1'b0;
                  res_q[ridx[k]] <= 1'b0;
               end
            end
            if (alloc_fire) begin
               tail_q <= tail_q + alloc_cnt;
               for (int k = 0; k < 3; k++) begin
                  if (alloc_valid_i[k]) begin
                     vld_q[atag[k]]  <= 1'b1;
                     res_q[atag[k]]  <= 1'b0;
                     mp_q[atag[k]]   <= 1'b0;
                     jalr_q[atag[k]] <= al_jalr[k];
                     pc_q[atag[k]]   <= al_pc[k];
                     cpc_q[atag[k]]  <= '0;
                     gh_q[atag[k]]   <= al_gh[k];
                     ras_q[atag[k]]  <= al_ras[k];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Testbench for branch_resolution_queue. The reference model keeps the queue
// as a program-ordered list of entries. A driver pushes the expected per-cycle
// outputs into a scoreboard. A monitor pops the scoreboard and compares each
// cycle's outputs.
module tb_branch_resolution_queue;
   localparam int DW = 32, DEPTH = 16, GHW = 8, TW = 4;
`ifdef BRQ_CORRECT_UPDATE_EN
   localparam bit CU = 1'b1;
`else
   localparam bit CU = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]        alloc_valid_i = '0, resolve_valid_i = '0;
   logic              a_jalr_s [3];
   logic [DW-1:0]     a_pc_s [3];
   logic [GHW-1:0]    a_gh_s [3];
   logic [2:0]        a_ras_s [3];
   logic [TW-1:0]     r_tag_s [3];
   logic              r_mp_s [3];
   logic [DW-1:0]     r_cpc_s [3];
   logic              alloc_ready_o, empty_o, full_o, ras_en_o;
   logic [2:0]        ras_tos_o;
   logic [TW:0]       occ_o;
   logic [TW-1:0]     tag_o [3];
   logic              mp_o [3], uv_o [3], jalr_o [3];
   logic [DW-1:0]     pc_o [3], cpc_o [3];
   logic [GHW-1:0]    gh_o [3];

   branch_resolution_queue dut (
      .clk(clk), .reset(reset), .alloc_valid_i(alloc_valid_i),
      .alloc_is_jalr_i_0(a_jalr_s[0]), .alloc_is_jalr_i_1(a_jalr_s[1]), .alloc_is_jalr_i_2(a_jalr_s[2]),
      .alloc_pc_at_prediction_i_0(a_pc_s[0]), .alloc_pc_at_prediction_i_1(a_pc_s[1]),
      .alloc_pc_at_prediction_i_2(a_pc_s[2]),
      .alloc_global_history_i_0(a_gh_s[0]), .alloc_global_history_i_1(a_gh_s[1]),
      .alloc_global_history_i_2(a_gh_s[2]),
      .alloc_ras_tos_i_0(a_ras_s[0]), .alloc_ras_tos_i_1(a_ras_s[1]), .alloc_ras_tos_i_2(a_ras_s[2]),
      .alloc_ready_o(alloc_ready_o),
      .alloc_tag_o_0(tag_o[0]), .alloc_tag_o_1(tag_o[1]), .alloc_tag_o_2(tag_o[2]),
      .resolve_valid_i(resolve_valid_i),
      .resolve_tag_i_0(r_tag_s[0]), .resolve_tag_i_1(r_tag_s[1]), .resolve_tag_i_2(r_tag_s[2]),
      .resolve_mispredict_i_0(r_mp_s[0]), .resolve_mispredict_i_1(r_mp_s[1]),
      .resolve_mispredict_i_2(r_mp_s[2]),
      .resolve_correct_pc_i_0(r_cpc_s[0]), .resolve_correct_pc_i_1(r_cpc_s[1]),
      .resolve_correct_pc_i_2(r_cpc_s[2]),
      .misprediction_o_0(mp_o[0]), .misprediction_o_1(mp_o[1]), .misprediction_o_2(mp_o[2]),
      .update_valid_o_0(uv_o[0]), .update_valid_o_1(uv_o[1]), .update_valid_o_2(uv_o[2]),
      .is_jalr_o_0(jalr_o[0]), .is_jalr_o_1(jalr_o[1]), .is_jalr_o_2(jalr_o[2]),
      .pc_at_prediction_o_0(pc_o[0]), .pc_at_prediction_o_1(pc_o[1]), .pc_at_prediction_o_2(pc_o[2]),
      .correct_pc_o_0(cpc_o[0]), .correct_pc_o_1(cpc_o[1]), .correct_pc_o_2(cpc_o[2]),
      .update_global_history_o_0(gh_o[0]), .update_global_history_o_1(gh_o[1]),
      .update_global_history_o_2(gh_o[2]),
      .ras_restore_en_o(ras_en_o), .ras_restore_tos_o(ras_tos_o),
      .occupancy_o(occ_o), .empty_o(empty_o), .full_o(full_o)
   );

   typedef struct {
      logic jalr; logic [DW-1:0] pc; logic [GHW-1:0] gh; logic [2:0] ras;
      logic res; logic mp; logic [DW-1:0] cpc;
   } ent_t;

   typedef struct {
      logic [2:0] mp, uv, jalr;
      logic [2:0][DW-1:0] pc, cpc;
      logic [2:0][GHW-1:0] gh;
      logic ras_en; logic [2:0] ras_tos;
      int occ; logic empty, full, ready;
      logic [2:0][TW-1:0] tag;
   } exp_t;

   ent_t mq[$];     // in-flight entries, oldest first
   int   head_ptr;  // tag of mq[0]
   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0;

   // Stimulus for the next step
   int                  a_num;
   logic [2:0]          a_jalr;
   logic [2:0][DW-1:0]  a_pc;
   logic [2:0][GHW-1:0] a_gh;
   logic [2:0][2:0]     a_ras;
   logic [2:0]          r_v, r_mp;
   logic [2:0][TW-1:0]  r_tag;
   logic [2:0][DW-1:0]  r_cpc;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle: record the expected outputs for the current state, drive the
   // inputs, and advance the model to the state after the next edge.
   task automatic step();
      exp_t e;
      int   nret, tl, idx;
      bit   fl, acc;
      ent_t t;
      @(negedge clk);
      e = '{default: '0};
      nret = 0; fl = 0;
      for (int k = 0; k < 3; k++) begin
         if (k >= mq.size() || fl) break;
         if (!mq[k].res) break;
         nret++;
         if (mq[k].mp) begin
            fl = 1; e.ras_en = 1; e.ras_tos = mq[k].ras; e.mp[k] = 1;
         end
         if (CU || mq[k].mp) begin
            e.uv[k] = 1; e.jalr[k] = mq[k].jalr; e.pc[k] = mq[k].pc;
            e.cpc[k] = mq[k].cpc; e.gh[k] = mq[k].gh;
         end
      end
      e.occ   = mq.size();
      e.empty = (mq.size() == 0);
      e.full  = (mq.size() == DEPTH);
      e.ready = ((DEPTH - mq.size()) >= 3) && !fl;
      tl = (head_ptr + mq.size()) % DEPTH;
      for (int k = 0; k < 3; k++) e.tag[k] = TW'((tl + k) % DEPTH);
      sb.push_back(e);
      acc = e.ready && (a_num > 0);
      // Resolving a slot that is being allocated in the same cycle is illegal.
      for (int k = 0; k < 3; k++)
         if (acc && r_v[k] && (((int'(r_tag[k]) - tl + DEPTH) % DEPTH) < a_num)) r_v[k] = 0;
      case (a_num)
         0: alloc_valid_i = 3'b000;
         1: alloc_valid_i = 3'b001;
         2: alloc_valid_i = 3'b011;
         default: alloc_valid_i = 3'b111;
      endcase
      resolve_valid_i = r_v;
      for (int k = 0; k < 3; k++) begin
         a_jalr_s[k] = a_jalr[k]; a_pc_s[k] = a_pc[k]; a_gh_s[k] = a_gh[k]; a_ras_s[k] = a_ras[k];
         r_tag_s[k] = r_tag[k]; r_mp_s[k] = r_mp[k]; r_cpc_s[k] = r_cpc[k];
      end
      // Model update: resolves (lowest lane first wins), retire/flush, allocate.
      for (int k = 0; k < 3; k++) begin
         if (r_v[k]) begin
            idx = (int'(r_tag[k]) - head_ptr + DEPTH) % DEPTH;
            if (idx < mq.size()) begin
               t = mq[idx];
               if (!t.res) begin
                  t.res = 1; t.mp = r_mp[k]; t.cpc = r_cpc[k];
                  mq[idx] = t;
               end
            end
         end
      end
      for (int k = 0; k < nret; k++) void'(mq.pop_front());
      head_ptr = (head_ptr + nret) % DEPTH;
      if (fl) mq.delete();
      if (acc)
         for (int k = 0; k < a_num; k++) begin
            t.jalr = a_jalr[k]; t.pc = a_pc[k]; t.gh = a_gh[k]; t.ras = a_ras[k];
            t.res = 0; t.mp = 0; t.cpc = '0;
            mq.push_back(t);
         end
   endtask

   task automatic clr();
      a_num = 0; r_v = '0; r_mp = '0; a_jalr = '0; a_pc = '0; a_gh = '0; a_ras = '0;
      r_tag = '0; r_cpc = '0;
   endtask

   task automatic idle();
      clr(); step();
   endtask

   task automatic alloc(input int n, input logic [DW-1:0] base);
      clr(); a_num = n;
      for (int k = 0; k < 3; k++) begin
         a_pc[k] = base + DW'(4 * k); a_jalr[k] = 1'($urandom);
         a_gh[k] = GHW'($urandom); a_ras[k] = 3'($urandom);
      end
   endtask

   task automatic resolve_front(input int n);
      int c;
      c = 0; clr();
      for (int i = 0; i < mq.size() && c < n; i++)
         if (!mq[i].res) begin
            r_v[c] = 1; r_tag[c] = TW'((head_ptr + i) % DEPTH); r_cpc[c] = DW'($urandom); c++;
         end
      step();
   endtask

   task automatic rnd_cycle(input int mp_div);
      clr();
      a_num = $urandom_range(0, 3);
      for (int k = 0; k < 3; k++) begin
         a_pc[k] = DW'($urandom) & ~32'h3; a_jalr[k] = 1'($urandom);
         a_gh[k] = GHW'($urandom); a_ras[k] = 3'($urandom);
         r_v[k] = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0 && $urandom_range(0, 9) < 8)
            r_tag[k] = TW'((head_ptr + $urandom_range(0, mq.size() - 1)) % DEPTH);
         else
            r_tag[k] = TW'($urandom_range(0, DEPTH - 1));
         r_mp[k] = ($urandom_range(0, mp_div - 1) == 0);
         r_cpc[k] = DW'($urandom) & ~32'h1;
      end
      step();
   endtask

   task automatic chk_reset_outputs(input string p);
      chk({p, "_empty"}, 64'(empty_o), 64'(1));
      chk({p, "_full"}, 64'(full_o), 64'(0));
      chk({p, "_occupancy"}, 64'(occ_o), 64'(0));
      chk({p, "_alloc_ready"}, 64'(alloc_ready_o), 64'(1));
      chk({p, "_ras_en"}, 64'(ras_en_o), 64'(0));
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_tag[%0d]", p, k), 64'(tag_o[k]), 64'(k));
         chk($sformatf("%s_uv[%0d]", p, k), 64'(uv_o[k]), 64'(0));
         chk($sformatf("%s_mp[%0d]", p, k), 64'(mp_o[k]), 64'(0));
      end
   endtask

   task automatic mid_reset();
      @(negedge clk); #3;
      reset = 1'b0; #1;
      chk_reset_outputs("midrst");
      mq.delete(); head_ptr = 0; clr();
      alloc_valid_i = '0; resolve_valid_i = '0;
      @(negedge clk); #3;
      reset = 1'b1;
   endtask

   // Monitor: compares the outputs of each recorded cycle against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("occupancy", 64'(occ_o), 64'(e.occ));
            chk("empty", 64'(empty_o), 64'(e.empty));
            chk("full", 64'(full_o), 64'(e.full));
            chk("alloc_ready", 64'(alloc_ready_o), 64'(e.ready));
            chk("ras_en", 64'(ras_en_o), 64'(e.ras_en));
            if (e.ras_en) chk("ras_tos", 64'(ras_tos_o), 64'(e.ras_tos));
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("alloc_tag[%0d]", k), 64'(tag_o[k]), 64'(e.tag[k]));
               chk($sformatf("mispredict[%0d]", k), 64'(mp_o[k]), 64'(e.mp[k]));
               chk($sformatf("update_valid[%0d]", k), 64'(uv_o[k]), 64'(e.uv[k]));
               chk($sformatf("is_jalr[%0d]", k), 64'(jalr_o[k]), 64'(e.jalr[k]));
               chk($sformatf("pc[%0d]", k), 64'(pc_o[k]), 64'(e.pc[k]));
               chk($sformatf("correct_pc[%0d]", k), 64'(cpc_o[k]), 64'(e.cpc[k]));
               chk($sformatf("ghist[%0d]", k), 64'(gh_o[k]), 64'(e.gh[k]));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      head_ptr = 0; clr();
      for (int k = 0; k < 3; k++) begin
         a_jalr_s[k] = 0; a_pc_s[k] = '0; a_gh_s[k] = '0; a_ras_s[k] = '0;
         r_tag_s[k] = '0; r_mp_s[k] = 0; r_cpc_s[k] = '0;
      end
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      #3 reset = 1'b1;

      // Three allocations resolved together, then retired together.
      idle();
      alloc(3, 32'h100); step();
      clr(); r_v = 3'b111; r_tag = {4'd2, 4'd1, 4'd0}; step();
      idle(); idle();

      // Out-of-order resolution: 5, then 3, then 4.
      alloc(3, 32'h300); step();
      clr(); r_v = 3'b001; r_tag[0] = 4'd5; step();
      clr(); r_v = 3'b001; r_tag[0] = 4'd3; step();
      clr(); r_v = 3'b001; r_tag[0] = 4'd4; step();
      idle(); idle();

      // Five entries (tags 6..10); tag 7 mispredicts to 0x200 with ras_tos 5.
      alloc(3, 32'h400); a_ras[1] = 3'd5; step();
      alloc(2, 32'h40c); step();
      clr(); r_v = 3'b111; r_tag = {4'd8, 4'd7, 4'd6}; r_mp[1] = 1; r_cpc[1] = 32'h200; step();
      clr(); r_v = 3'b011; r_tag[0] = 4'd9; r_tag[1] = 4'd10; step();
      idle(); idle();
      // Resolve of a flushed tag: no effect.
      clr(); r_v = 3'b001; r_tag[0] = 4'd9; r_mp[0] = 1; step();
      idle();

      // Fill to DEPTH across the pointer wrap, try one more, then drain.
      alloc(1, 32'h500); step();
      for (int i = 0; i < 5; i++) begin alloc(3, 32'h600 + 32'(16 * i)); step(); end
      alloc(3, 32'h700); step();
      for (int i = 0; i < 7; i++) resolve_front(3);
      repeat (3) idle();

      // Randomized traffic, with an asynchronous reset in the middle.
      for (int i = 0; i < 1500; i++) rnd_cycle((i < 750) ? 40 : 8);
      mid_reset();
      idle();
      for (int i = 0; i < 1500; i++) rnd_cycle((i < 750) ? 8 : 40);
      repeat (3) idle();

      @(negedge clk); #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
